uart_baud_gen: RTL and testbench

Parametrised baud/oversample tick generator for the UART transmitter and receiver, the programmable successor to the fixed-ratio prescaler. It produces one-cycle oversample ticks at a fractional divisor of `clock`, plus derived mid-bit and bit-boundary ticks and the oversample phase. The divisor is runtime-loadable and takes effect glitch-free at bit boundaries. A resync input lets the RX path realign phase on a start-bit edge.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/frac_tick_core.sv | 65 ++++++
 rtl/uart_baud_gen.sv | 136 +++++++++++++
 tb/tb_uart_baud_gen.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART baud/oversample tick generator.
// default_div() gives the fixed-point reset divisor, FRAC_BITS fractional bits.
package uart_pkg;

    localparam int MIN_DIV        = 2;
    localparam int OVERSAMPLE_DEF = 16;

    // round(clk_hz * 2^frac_bits / (baud * os))
    function automatic longint unsigned default_div(
        input longint unsigned clk_hz,
        input longint unsigned baud,
        input longint unsigned os,
        input longint unsigned frac_bits
    );
        longint unsigned num;
        longint unsigned den;
        num = clk_hz << frac_bits;
        den = baud * os;
        return (num + (den >> 1)) / den;
    endfunction

endpackage

// File: rtl/frac_tick_core.sv
// Fractional period counter: cnt counts 0..P-1 with P = int_i + extra, and
// facc accumulates frac_i once per period to spread the fractional clocks.
// Ports: clock_i/reset_ni (async active-low), en_i freezes state,
//   clr_i restarts the period, int_i (already clamped >= 2), frac_i,
//   wrap_o = this edge ends the period (gated by en_i, suppressed by clr_i).
module frac_tick_core
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH = 16,
    parameter int FRAC_BITS = 4
) (
    input  logic                 clock_i,
    input  logic                 reset_ni,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic [DIV_WIDTH-1:0] int_i,
    input  logic [FRAC_BITS-1:0] frac_i,
    output logic                 wrap_o
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [FRAC_BITS-1:0] facc_q, facc_d;
    logic [FRAC_BITS:0]   fsum;
    logic                 extra;
    logic [DIV_WIDTH:0]   last;
    logic                 at_last;

    // extra is the carry this period's accumulation will produce, so the
    // long clock lands in the period that completes the fractional unit.
    assign fsum  = {1'b0, facc_q} + {1'b0, frac_i};
    assign extra = fsum[FRAC_BITS];
    assign last  = {1'b0, int_i} + {{DIV_WIDTH{1'b0}}, extra}
                 - (DIV_WIDTH+1)'(1);

    // >= rather than == keeps a freshly shortened divisor from running away.
    assign at_last = ({1'b0, cnt_q} >= last);
    assign wrap_o  = en_i & ~clr_i & at_last;

    always_comb begin
        cnt_d  = cnt_q;
        facc_d = facc_q;
        if (clr_i) begin
            cnt_d  = '0;
            facc_d = '0;
        end else if (en_i) begin
            if (at_last) begin
                cnt_d  = '0;
                facc_d = fsum[FRAC_BITS-1:0];
            end else begin
                cnt_d = cnt_q + DIV_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q  <= '0;
            facc_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            facc_q <= facc_d;
        end
    end

endmodule

// File: rtl/uart_baud_gen.sv
// Programmable UART oversample tick generator with fractional divisor,
// glitch-free divisor reload at bit boundaries and start-bit phase resync.
// Ports: clock, reset_n (async active-low), enable, resync,
//   div_int/div_frac/div_load (divisor load), div_pending,
//   os_tick, os_phase, mid_tick, bit_tick.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DIV_WIDTH  = 16,
    parameter int FRAC_BITS  = 4,
    localparam int PW        = $clog2(OVERSAMPLE)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 resync,
    input  logic [DIV_WIDTH-1:0] div_int,
    input  logic [FRAC_BITS-1:0] div_frac,
    input  logic                 div_load,
    output logic                 div_pending,
    output logic                 os_tick,
    output logic [PW-1:0]        os_phase,
    output logic                 mid_tick,
    output logic                 bit_tick
);

    localparam longint unsigned RST_DIV =
        default_div(64'(CLK_HZ), 64'(BAUD), 64'(OVERSAMPLE), 64'(FRAC_BITS));
    localparam logic [DIV_WIDTH-1:0] RST_INT  = DIV_WIDTH'(RST_DIV >> FRAC_BITS);
    localparam logic [FRAC_BITS-1:0] RST_FRAC = FRAC_BITS'(RST_DIV);
    localparam logic [DIV_WIDTH-1:0] MIN_D    = DIV_WIDTH'(MIN_DIV);
    localparam logic [PW-1:0]        MID_PH   = PW'(OVERSAMPLE/2 - 1);
    localparam logic [PW-1:0]        LAST_PH  = PW'(OVERSAMPLE - 1);

    logic [DIV_WIDTH-1:0] act_int_q, act_int_d;
    logic [FRAC_BITS-1:0] act_frac_q, act_frac_d;
    logic [DIV_WIDTH-1:0] sh_int_q, sh_int_d;
    logic [FRAC_BITS-1:0] sh_frac_q, sh_frac_d;
    logic                 pend_q, pend_d;
    logic                 tick_q;
    logic [PW-1:0]        phase_q, phase_d;
    logic [PW-1:0]        nxt_q, nxt_d;
    logic [DIV_WIDTH-1:0] eff_int;
    logic                 wrap;

    assign eff_int = (act_int_q < MIN_D) ? MIN_D : act_int_q;

    frac_tick_core #(
        .DIV_WIDTH (DIV_WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_core (
        .clock_i  (clock),
        .reset_ni (reset_n),
        .en_i     (enable),
        .clr_i    (resync),
        .int_i    (eff_int),
        .frac_i   (act_frac_q),
        .wrap_o   (wrap)
    );

    assign os_tick     = tick_q & enable;
    assign mid_tick    = os_tick & (phase_q == MID_PH);
    assign bit_tick    = os_tick & (phase_q == LAST_PH);
    assign os_phase    = phase_q;
    assign div_pending = pend_q;

    always_comb begin
        act_int_d  = act_int_q;
        act_frac_d = act_frac_q;
        sh_int_d   = sh_int_q;
        sh_frac_d  = sh_frac_q;
        pend_d     = pend_q;
        phase_d    = phase_q;
        nxt_d      = nxt_q;

        // nxt_q is the phase the next tick will carry, so the first tick
        // after reset or resync reports phase 0.
        if (resync) begin
            phase_d = '0;
            nxt_d   = '0;
        end else if (wrap) begin
            phase_d = nxt_q;
            nxt_d   = nxt_q + PW'(1);
        end

        if (resync) begin
            pend_d = 1'b0;
            if (div_load) begin
                act_int_d  = div_int;
                act_frac_d = div_frac;
                sh_int_d   = div_int;
                sh_frac_d  = div_frac;
            end else if (pend_q) begin
                act_int_d  = sh_int_q;
                act_frac_d = sh_frac_q;
            end
        end else begin
            if (pend_q && (bit_tick || !enable)) begin
                act_int_d  = sh_int_q;
                act_frac_d = sh_frac_q;
                pend_d     = 1'b0;
            end
            if (div_load) begin
                sh_int_d  = div_int;
                sh_frac_d = div_frac;
                pend_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            act_int_q  <= RST_INT;
            act_frac_q <= RST_FRAC;
            sh_int_q   <= RST_INT;
            sh_frac_q  <= RST_FRAC;
            pend_q     <= 1'b0;
            tick_q     <= 1'b0;
            phase_q    <= '0;
            nxt_q      <= '0;
        end else begin
            act_int_q  <= act_int_d;
            act_frac_q <= act_frac_d;
            sh_int_q   <= sh_int_d;
            sh_frac_q  <= sh_frac_d;
            pend_q     <= pend_d;
            tick_q     <= wrap;
            phase_q    <= phase_d;
            nxt_q      <= nxt_d;
        end
    end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen: vector table of divisors plus
// sequences for reload, resync, enable hold and mid-bit reset.
module tb_uart_baud_gen;

    logic        clock;
    logic        reset_n;
    logic        enable;
    logic        resync;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic        div_load;
    logic        div_pending;
    logic        os_tick;
    logic [3:0]  os_phase;
    logic        mid_tick;
    logic        bit_tick;

    uart_baud_gen dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .resync      (resync),
        .div_int     (div_int),
        .div_frac    (div_frac),
        .div_load    (div_load),
        .div_pending (div_pending),
        .os_tick     (os_tick),
        .os_phase    (os_phase),
        .mid_tick    (mid_tick),
        .bit_tick    (bit_tick)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    int tick_rel [0:32];
    int tick_abs [0:32];
    int ph       [0:32];
    int mt       [0:32];
    int bt       [0:32];

    typedef struct {
        int di;
        int df;
        int n;
        int span;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Collect n ticks; times are edges since the call point.
    task automatic collect(input int n, input int limit);
        int k;
        int t0;
        k = 0;
        t0 = cyc;
        tick_rel[0] = 0;
        while (k < n && (cyc - t0) < limit) begin
            @(posedge clock); #1;
            if (os_tick) begin
                k++;
                tick_rel[k] = cyc - t0;
                tick_abs[k] = cyc;
                ph[k] = int'(os_phase);
                mt[k] = int'(mid_tick);
                bt[k] = int'(bit_tick);
            end
        end
        if (k < n) chk("collect_timeout", k, n);
    endtask

    task automatic load_now(input int di, input int df);
        div_int  = 16'(di);
        div_frac = 4'(df);
        resync   = 1'b1;
        div_load = 1'b1;
        @(posedge clock); #1;
        resync   = 1'b0;
        div_load = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int mids;
        int bits;
        int found;
        int drops;
        int bad;
        int c0;
        int c1;

        vecs[0] = '{0,  0,  4,  8};
        vecs[1] = '{1,  0,  4,  8};
        vecs[2] = '{2,  0,  4,  8};
        vecs[3] = '{5,  0,  3,  15};
        vecs[4] = '{27, 2,  16, 434};
        vecs[5] = '{3,  8,  2,  7};
        vecs[6] = '{4,  15, 2,  9};
        vecs[7] = '{10, 4,  4,  41};

        reset_n  = 1'b0;
        enable   = 1'b1;
        resync   = 1'b0;
        div_int  = '0;
        div_frac = '0;
        div_load = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        chk("rst_os_tick", int'(os_tick), 0);
        chk("rst_mid", int'(mid_tick), 0);
        chk("rst_bit", int'(bit_tick), 0);
        chk("rst_pending", int'(div_pending), 0);
        chk("rst_phase", int'(os_phase), 0);

        // Default divisor 27 + 2/16
        collect(16, 600);
        mids = 0;
        bits = 0;
        for (int k = 1; k <= 16; k++) begin
            chk($sformatf("def_gap%0d", k),
                tick_rel[k] - tick_rel[k-1],
                (k == 8 || k == 16) ? 28 : 27);
            chk($sformatf("def_ph%0d", k), ph[k], k - 1);
            mids += mt[k];
            bits += bt[k];
        end
        chk("def_span", tick_rel[16], 434);
        chk("def_mid8", mt[8], 1);
        chk("def_bit16", bt[16], 1);
        chk("def_mid_count", mids, 1);
        chk("def_bit_count", bits, 1);

        // Vector table: resync + load, then measure span
        for (int i = 0; i < 8; i++) begin
            div_int  = 16'(vecs[i].di);
            div_frac = 4'(vecs[i].df);
            resync   = 1'b1;
            div_load = 1'b1;
            @(posedge clock); #1;
            chk($sformatf("vec%0d_pend", i), int'(div_pending), 0);
            chk($sformatf("vec%0d_notick", i), int'(os_tick), 0);
            resync   = 1'b0;
            div_load = 1'b0;
            collect(vecs[i].n, 2000);
            chk($sformatf("vec%0d_span", i), tick_rel[vecs[i].n], vecs[i].span);
            chk($sformatf("vec%0d_ph0", i), ph[1], 0);
        end

        // Mid-bit load of 2/0 applies after bit_tick
        load_now(27, 2);
        collect(3, 200);
        div_int  = 16'd2;
        div_frac = 4'd0;
        div_load = 1'b1;
        @(posedge clock); #1;
        div_load = 1'b0;
        chk("ld_pend_set", int'(div_pending), 1);
        found = 0;
        drops = 0;
        for (int j = 0; j < 600 && found == 0; j++) begin
            @(posedge clock); #1;
            if (bit_tick) found = 1;
            else if (!div_pending) drops++;
        end
        chk("ld_bit_seen", found, 1);
        chk("ld_pend_held", drops, 0);
        chk("ld_pend_at_bit", int'(div_pending), 1);
        c0 = cyc;
        @(posedge clock); #1;
        chk("ld_pend_clr", int'(div_pending), 0);
        collect(4, 100);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("ld_tick%0d", k), tick_abs[k] - c0, 2 * k);
        end
        chk("ld_ph_wrap", ph[1], 0);

        // Resync at phase 5 on a would-be tick edge, with same-cycle load
        load_now(27, 2);
        collect(6, 400);
        chk("rs_ph5", ph[6], 5);
        repeat (26) @(posedge clock);
        #1;
        div_int  = 16'd7;
        div_frac = 4'd0;
        resync   = 1'b1;
        div_load = 1'b1;
        @(posedge clock); #1;
        chk("rs_notick", int'(os_tick), 0);
        chk("rs_phase", int'(os_phase), 0);
        chk("rs_pend", int'(div_pending), 0);
        resync   = 1'b0;
        div_load = 1'b0;
        collect(2, 100);
        chk("rs_t1", tick_rel[1], 7);
        chk("rs_t2", tick_rel[2], 14);
        chk("rs_ph_a", ph[1], 0);
        chk("rs_ph_b", ph[2], 1);

        // Two loads while pending: last wins, resync applies it
        div_int  = 16'd9;
        div_load = 1'b1;
        @(posedge clock); #1;
        div_int = 16'd3;
        @(posedge clock); #1;
        div_load = 1'b0;
        chk("llw_pend", int'(div_pending), 1);
        resync = 1'b1;
        @(posedge clock); #1;
        resync = 1'b0;
        chk("llw_pend_clr", int'(div_pending), 0);
        collect(2, 100);
        chk("llw_t1", tick_rel[1], 3);
        chk("llw_t2", tick_rel[2], 6);

        // Enable low for 10 cycles mid-period
        load_now(27, 2);
        collect(1, 100);
        c1 = tick_abs[1];
        repeat (10) @(posedge clock);
        #1;
        enable = 1'b0;
        bad = 0;
        for (int j = 0; j < 10; j++) begin
            @(posedge clock); #1;
            if (os_tick || mid_tick || bit_tick) bad++;
            if (os_phase != 4'd0) bad++;
        end
        chk("en_hold", bad, 0);
        enable = 1'b1;
        collect(1, 100);
        chk("en_period", tick_abs[1] - c1, 37);
        chk("en_phase", ph[1], 1);

        // Reset mid-bit with a non-default divisor and a pending load
        load_now(5, 0);
        collect(2, 50);
        div_int  = 16'd2;
        div_load = 1'b1;
        @(posedge clock); #1;
        div_load = 1'b0;
        chk("mr_pend_pre", int'(div_pending), 1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("mr_os_tick", int'(os_tick), 0);
        chk("mr_mid", int'(mid_tick), 0);
        chk("mr_bit", int'(bit_tick), 0);
        chk("mr_pending", int'(div_pending), 0);
        chk("mr_phase", int'(os_phase), 0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        collect(1, 100);
        chk("mr_first", tick_rel[1], 27);
        chk("mr_ph0", ph[1], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
